cl_serial_cmd_ctrl: RTL and testbench

- Command/response sequencer for the CameraLink serial channel, directly upstream and downstream of the uart block.
- Buffers a host-written ASCII command and feeds it byte-by-byte into the UART transmitter using the tx_start/tx_busy handshake.
- Collects the camera's reply from rx_ready/rx_data into a response buffer until TERM_CHAR is received or a timeout expires.
- The response buffer is then readable by the host.

---
 rtl/cl_serial_cmd_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cl_serial_cmd_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_serial_cmd_ctrl.sv
// CameraLink serial command/response sequencer sitting between the host and the uart block.
// Buffers a host command, streams it through the UART tx handshake and collects the reply.
module cl_serial_cmd_ctrl #(
    parameter int unsigned MAX_CMD_LEN    = 16,
    parameter int unsigned MAX_RSP_LEN    = 32,
    parameter logic [7:0]  TERM_CHAR      = 8'h0D,
    parameter int unsigned TIMEOUT_CYCLES = 12500000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_wr_en,
    input  logic [7:0]                       cmd_wr_data,
    input  logic                             cmd_go,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout,
    output logic                             rsp_overflow,
    output logic [$clog2(MAX_RSP_LEN+1)-1:0] rsp_len,
    input  logic [$clog2(MAX_RSP_LEN)-1:0]   rsp_rd_addr,
    output logic [7:0]                       rsp_rd_data,
    output logic                             tx_start,
    output logic [7:0]                       tx_data,
    input  logic                             tx_busy,
    input  logic                             rx_ready,
    input  logic [7:0]                       rx_data
);

    localparam int unsigned CCW = $clog2(MAX_CMD_LEN + 1);
    localparam int unsigned CIW = $clog2(MAX_CMD_LEN);
    localparam int unsigned RLW = $clog2(MAX_RSP_LEN + 1);
    localparam int unsigned RAW = $clog2(MAX_RSP_LEN);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CCW-1:0] CMD_FULL = CCW'(MAX_CMD_LEN);
    localparam logic [RLW-1:0] RSP_FULL = RLW'(MAX_RSP_LEN);
    localparam logic [TW-1:0]  TMO_LOAD = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX_LOAD  = 3'd1,
        TX_ACK   = 3'd2,
        TX_DRAIN = 3'd3,
        RECV     = 3'd4,
        FINISH   = 3'd5
    } state_t;

    state_t         state;
    state_t         next_state;

    logic [7:0]     cmd_buf [MAX_CMD_LEN];
    logic [7:0]     rsp_buf [MAX_RSP_LEN];
    logic [CCW-1:0] cmd_cnt;
    logic [CIW-1:0] tx_idx;
    logic [TW-1:0]  tmo_cnt;
    logic           term_seen;

    logic           wr_ok;
    logic           go_ok;
    logic           capture;
    logic           rx_term;
    logic           rx_store;
    logic           rx_drop;
    logic           last_byte;
    logic           tmo_expire;
    logic           drain_done;

    logic           launch;
    logic           busy_d;
    logic           done_d;

    // Qualified events shared by the FSM and the datapath
    assign wr_ok      = (state == IDLE) && cmd_wr_en && (cmd_cnt != CMD_FULL);
    assign go_ok      = (state == IDLE) && cmd_go && ((cmd_cnt != '0) || cmd_wr_en);
    assign capture    = (state inside {TX_LOAD, TX_ACK, TX_DRAIN, RECV}) && rx_ready && !term_seen;
    assign rx_term    = capture && (rx_data == TERM_CHAR);
    assign rx_store   = capture && (rx_data != TERM_CHAR) && (rsp_len != RSP_FULL);
    assign rx_drop    = capture && (rx_data != TERM_CHAR) && (rsp_len == RSP_FULL);
    assign last_byte  = (CCW'(tx_idx) == (cmd_cnt - CCW'(1)));
    assign drain_done = (state == TX_DRAIN) && !tx_busy;
    // Any rx_ready reloads the counter, so a terminator can never lose to expiry
    assign tmo_expire = (state == RECV) && !term_seen && !rx_ready && (tmo_cnt == TW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (go_ok) next_state = TX_LOAD;
            TX_LOAD:  if (!tx_busy) next_state = TX_ACK;
            TX_ACK:   if (tx_busy) next_state = TX_DRAIN;
            TX_DRAIN: if (!tx_busy) next_state = last_byte ? RECV : TX_LOAD;
            RECV:     if (term_seen || tmo_expire) next_state = FINISH;
            FINISH:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Output decode, registered below
    always_comb begin
        launch = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state == TX_LOAD && !tx_busy) launch = 1'b1;
        if (next_state inside {TX_LOAD, TX_ACK, TX_DRAIN, RECV}) busy_d = 1'b1;
        if (next_state == FINISH) done_d = 1'b1;
    end

    // Control registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_len      <= '0;
            rsp_rd_data  <= '0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            cmd_cnt      <= '0;
            tx_idx       <= '0;
            tmo_cnt      <= '0;
            term_seen    <= 1'b0;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            tx_start    <= launch;
            rsp_rd_data <= rsp_buf[rsp_rd_addr];
            if (launch) tx_data <= cmd_buf[tx_idx];
            if (wr_ok) cmd_cnt <= cmd_cnt + CCW'(1);
            if (go_ok) begin
                rsp_len      <= '0;
                timeout      <= 1'b0;
                rsp_overflow <= 1'b0;
                tx_idx       <= '0;
            end
            if (drain_done) begin
                if (last_byte) begin
                    cmd_cnt <= '0;
                    tmo_cnt <= TMO_LOAD;
                end else begin
                    tx_idx <= tx_idx + CIW'(1);
                end
            end
            if (rx_store) rsp_len <= rsp_len + RLW'(1);
            if (rx_drop) rsp_overflow <= 1'b1;
            if (rx_term) term_seen <= 1'b1;
            if (state == RECV) begin
                if (rx_ready)              tmo_cnt <= TMO_LOAD;
                else if (tmo_cnt != '0)    tmo_cnt <= tmo_cnt - TW'(1);
                if (tmo_expire)            timeout <= 1'b1;
            end
            if (state == FINISH) term_seen <= 1'b0;
        end
    end

    // Command and response storage, no reset needed
    always_ff @(posedge clk) begin
        if (!rst && wr_ok)    cmd_buf[CIW'(cmd_cnt)] <= cmd_wr_data;
        if (!rst && rx_store) rsp_buf[RAW'(rsp_len)] <= rx_data;
    end

endmodule

// File: tb/tb_cl_serial_cmd_ctrl.sv
// Directed bench for cl_serial_cmd_ctrl with a behavioural UART transmitter (16 clk/bit, 10-bit frame).
module tb_cl_serial_cmd_ctrl;

    localparam int unsigned TMO   = 1000;
    localparam int unsigned FRAME = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_wr_en = 1'b0;
    logic [7:0] cmd_wr_data = 8'h00;
    logic       cmd_go = 1'b0;
    logic       busy, done, timeout, rsp_overflow;
    logic [5:0] rsp_len;
    logic [4:0] rsp_rd_addr = 5'd0;
    logic [7:0] rsp_rd_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    cl_serial_cmd_ctrl #(
        .MAX_CMD_LEN(16), .MAX_RSP_LEN(32), .TERM_CHAR(8'h0D), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .cmd_wr_en(cmd_wr_en), .cmd_wr_data(cmd_wr_data),
        .cmd_go(cmd_go), .busy(busy), .done(done), .timeout(timeout),
        .rsp_overflow(rsp_overflow), .rsp_len(rsp_len), .rsp_rd_addr(rsp_rd_addr),
        .rsp_rd_data(rsp_rd_data), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .rx_ready(rx_ready), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    // UART transmitter model plus tx/done logging
    int unsigned busy_cnt   = 0;
    int unsigned tx_total   = 0;
    int unsigned done_total = 0;
    logic [7:0]  tx_log [256];

    always @(posedge clk) begin
        if (rst)                 busy_cnt <= 0;
        else if (tx_start)       busy_cnt <= FRAME;
        else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
        if (tx_start) begin
            tx_log[tx_total[7:0]] <= tx_data;
            tx_total <= tx_total + 1;
        end
        if (done) done_total <= done_total + 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr_byte(input logic [7:0] b);
        cmd_wr_en = 1'b1;
        cmd_wr_data = b;
        @(negedge clk);
        cmd_wr_en = 1'b0;
    endtask

    task automatic pulse_go();
        cmd_go = 1'b1;
        @(negedge clk);
        cmd_go = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input int gap);
        rx_ready = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Returns at the first negedge where n_target bytes were sent and the UART is idle
    task automatic wait_tx(input int unsigned n_target, input int max, input string tag);
        int k = 0;
        while (!(tx_total >= n_target && !tx_busy) && k < max) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(tx_total >= n_target && !tx_busy), 1);
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (!done && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic rd_check(input logic [4:0] addr, input logic [7:0] exp, input string tag);
        rsp_rd_addr = addr;
        @(negedge clk);
        check(tag, 32'(rsp_rd_data), 32'(exp));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  id_cmd [4];
        int unsigned s;
        int unsigned d0;
        int          cyc;
        int          errs;
        id_cmd = '{8'h49, 8'h44, 8'h3F, 8'h0D};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_rsp_len", 32'(rsp_len), 0);
        check("rst_flags", 32'({timeout, rsp_overflow}), 0);
        rst = 1'b0;
        @(negedge clk);

        // "ID?\r" with "OK\r" reply
        for (int i = 0; i < 4; i++) wr_byte(id_cmd[i]);
        s = tx_total;
        d0 = done_total;
        cmd_go = 1'b1;
        @(negedge clk);
        cmd_go = 1'b0;
        check("t1_busy", 32'(busy), 1);
        @(negedge clk);
        check("t1_tx_start_latency", 32'(tx_start), 1);
        check("t1_tx_data0", 32'(tx_data), 32'h49);
        @(negedge clk);
        check("t1_tx_start_width", 32'(tx_start), 0);
        wait_tx(s + 4, 4 * 200, "t1_tx_complete");
        send_rx(8'h4F, 5);
        send_rx(8'h4B, 5);
        send_rx(8'h0D, 0);
        wait_done(50, cyc);
        check("t1_done", 32'(done), 1);
        repeat (5) @(negedge clk);
        check("t1_tx_count", tx_total - s, 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("t1_tx_byte%0d", k), 32'(tx_log[8'(s + k)]), 32'(id_cmd[k]));
        check("t1_done_count", done_total - d0, 1);
        check("t1_rsp_len", 32'(rsp_len), 2);
        check("t1_timeout", 32'(timeout), 0);
        check("t1_busy_end", 32'(busy), 0);
        rd_check(5'd0, 8'h4F, "t1_rsp0");
        rd_check(5'd1, 8'h4B, "t1_rsp1");

        // One-byte command, no reply: timeout
        wr_byte(8'h41);
        s = tx_total;
        pulse_go();
        wait_tx(s + 1, 300, "t2_tx_complete");
        wait_done(TMO + 100, cyc);
        check("t2_done", 32'(done), 1);
        check("t2_latency_in_window", 32'((cyc - 1) >= 998 && (cyc - 1) <= 1002), 1);
        @(negedge clk);
        check("t2_timeout", 32'(timeout), 1);
        check("t2_rsp_len", 32'(rsp_len), 0);
        repeat (2) @(negedge clk);

        // 40-byte reply overflows a 32-byte buffer
        wr_byte(8'h42);
        s = tx_total;
        pulse_go();
        check("t3_flags_cleared", 32'(timeout), 0);
        wait_tx(s + 1, 300, "t3_tx_complete");
        for (int i = 0; i < 40; i++) send_rx(8'(8'h20 + i), 10);
        send_rx(8'h0D, 0);
        wait_done(50, cyc);
        check("t3_done", 32'(done), 1);
        @(negedge clk);
        check("t3_rsp_len", 32'(rsp_len), 32);
        check("t3_overflow", 32'(rsp_overflow), 1);
        check("t3_timeout", 32'(timeout), 0);
        rd_check(5'd31, 8'h3F, "t3_rsp31");
        rd_check(5'd0, 8'h20, "t3_rsp0");

        // 20 writes into a 16-deep buffer, extra writes while busy
        for (int i = 0; i < 20; i++) wr_byte(8'(8'h60 + i));
        s = tx_total;
        d0 = done_total;
        pulse_go();
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) wr_byte(8'hFF);
        wait_tx(s + 16, 16 * 200, "t4_tx_complete");
        wait_done(TMO + 100, cyc);
        check("t4_done", 32'(done), 1);
        repeat (3) @(negedge clk);
        check("t4_tx_count", tx_total - s, 16);
        errs = 0;
        for (int k = 0; k < 16; k++)
            if (tx_log[8'(s + k)] !== 8'(8'h60 + k)) errs++;
        check("t4_tx_sequence_errors", 32'(errs), 0);
        check("t4_last_byte", 32'(tx_log[8'(s + 15)]), 32'h6F);
        check("t4_timeout", 32'(timeout), 1);
        check("t4_done_count", done_total - d0, 1);

        // Terminator arrives while the third of five bytes is on the wire
        for (int i = 0; i < 5; i++) wr_byte(8'(8'h31 + i));
        s = tx_total;
        pulse_go();
        cyc = 0;
        while (tx_total < s + 3 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_third_started", 32'(tx_total - s), 3);
        send_rx(8'h0D, 0);
        wait_tx(s + 5, 5 * 200, "t5_tx_complete");
        wait_done(10, cyc);
        check("t5_done", 32'(done), 1);
        check("t5_done_latency_ok", 32'(cyc <= 3), 1);
        @(negedge clk);
        check("t5_tx_count", tx_total - s, 5);
        check("t5_tx_last", 32'(tx_log[8'(s + 4)]), 32'h35);
        check("t5_timeout", 32'(timeout), 0);
        check("t5_rsp_len", 32'(rsp_len), 0);
        repeat (2) @(negedge clk);

        // Reset during TX_ACK
        wr_byte(8'h51);
        wr_byte(8'h52);
        d0 = done_total;
        cmd_go = 1'b1;
        @(negedge clk);
        cmd_go = 1'b0;
        @(negedge clk);
        check("t6_tx_start_before_rst", 32'(tx_start), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_busy", 32'(busy), 0);
        check("t6_tx_start", 32'(tx_start), 0);
        check("t6_rsp_len", 32'(rsp_len), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_no_done", done_total - d0, 0);
        s = tx_total;
        pulse_go();
        check("t6_empty_go_busy", 32'(busy), 0);
        repeat (5) @(negedge clk);
        check("t6_empty_go_tx", tx_total - s, 0);
        check("t6_empty_go_done", done_total - d0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
